// File: rtl/unsigned_product_accumulator.sv
// Unsigned product accumulator: sums a programmed number of multiplier products
// into a wide accumulator and hands the total out over a valid/ready handshake.
// ACC_WIDTH must be at least PRODUCT_WIDTH.
module unsigned_product_accumulator #(
    parameter int unsigned PRODUCT_WIDTH = 16,
    parameter int unsigned ACC_WIDTH     = 24,
    parameter int unsigned COUNT_WIDTH   = 4
) (
    input  logic                     Clock_In,
    input  logic                     Reset_N_In,
    input  logic                     Start_In,
    input  logic [COUNT_WIDTH-1:0]   Length_In,
    output logic                     Enable_Out,
    input  logic [PRODUCT_WIDTH-1:0] Product_In,
    input  logic                     Product_Valid_In,
    output logic                     Product_Ready_Out,
    output logic [ACC_WIDTH-1:0]     Result_Out,
    output logic                     Result_Valid_Out,
    input  logic                     Result_Ready_In,
    output logic                     Overflow_Out,
    output logic                     Busy_Out
);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e                   state_q, state_d;
    logic [ACC_WIDTH-1:0]     acc_q, acc_d;
    logic [COUNT_WIDTH-1:0]   remaining_q, remaining_d;
    logic                     overflow_q, overflow_d;

    logic                     accept;
    logic [PRODUCT_WIDTH-1:0] product_gated;
    logic [ACC_WIDTH:0]       sum;

    // Gate the product bus so a floating multiplier output never reaches the adder.
    assign product_gated = Enable_Out ? Product_In : '0;
    assign accept        = (state_q == StAccum) && Product_Valid_In;
    // One extra bit catches the carry-out used for overflow detection.
    assign sum           = {1'b0, acc_q} + (ACC_WIDTH + 1)'(product_gated);

    // Outputs are decoded purely from the current state and the registered sum.
    always_comb begin
        Enable_Out        = (state_q == StAccum);
        Product_Ready_Out = (state_q == StAccum);
        Result_Valid_Out  = (state_q == StDone);
        Busy_Out          = (state_q == StAccum) || (state_q == StDone);
        Result_Out        = acc_q;
        Overflow_Out      = overflow_q;
    end

    // Next-state logic for the FSM, accumulator, term counter and sticky overflow.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        remaining_d = remaining_q;
        overflow_d  = overflow_q;
        unique case (state_q)
            StIdle: begin
                if (Start_In) begin
                    remaining_d = Length_In;
                    acc_d       = '0;
                    overflow_d  = 1'b0;
                    state_d     = (Length_In == '0) ? StDone : StAccum;
                end
            end
            StAccum: begin
                if (accept) begin
                    acc_d       = sum[ACC_WIDTH-1:0];
                    overflow_d  = overflow_q | sum[ACC_WIDTH];
                    remaining_d = remaining_q - COUNT_WIDTH'(1);
                    if (remaining_q == COUNT_WIDTH'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // Start is deliberately ignored here, even alongside the handshake.
                if (Result_Ready_In) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset; reset discards any partial sum.
    always_ff @(posedge Clock_In) begin
        if (!Reset_N_In) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            remaining_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_unsigned_product_accumulator.sv
// Bench for unsigned_product_accumulator: a 24-bit and a 17-bit accumulator run
// side by side on the same stimulus, with results checked through a scoreboard.
module tb_unsigned_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  length;
    logic [15:0] product;
    logic        pvalid;
    logic        rready;

    logic        en24, pready24, rv24, ovf24, busy24;
    logic [23:0] res24;
    logic        en17, pready17, rv17, ovf17, busy17;
    logic [16:0] res17;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0]        len;
        logic [15:0][15:0] prod;
        logic [15:0][1:0]  gap;   // idle beats inserted before each term
        logic [23:0]       r24;
        logic              o24;
        logic [16:0]       r17;
        logic              o17;
    } vec_t;

    typedef struct packed {
        logic [23:0] r24;
        logic        o24;
        logic [16:0] r17;
        logic        o17;
    } exp_t;

    vec_t vecs [7];
    exp_t sb [$];

    always #5 clk = ~clk;

    unsigned_product_accumulator dut24 (
        .Clock_In          (clk),
        .Reset_N_In        (rst_n),
        .Start_In          (start),
        .Length_In         (length),
        .Enable_Out        (en24),
        .Product_In        (product),
        .Product_Valid_In  (pvalid),
        .Product_Ready_Out (pready24),
        .Result_Out        (res24),
        .Result_Valid_Out  (rv24),
        .Result_Ready_In   (rready),
        .Overflow_Out      (ovf24),
        .Busy_Out          (busy24)
    );

    unsigned_product_accumulator #(.ACC_WIDTH(17)) dut17 (
        .Clock_In          (clk),
        .Reset_N_In        (rst_n),
        .Start_In          (start),
        .Length_In         (length),
        .Enable_Out        (en17),
        .Product_In        (product),
        .Product_Valid_In  (pvalid),
        .Product_Ready_Out (pready17),
        .Result_Out        (res17),
        .Result_Valid_Out  (rv17),
        .Result_Ready_In   (rready),
        .Overflow_Out      (ovf17),
        .Busy_Out          (busy17)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en24"}, en24, 0);
        check({tag, "_pready24"}, pready24, 0);
        check({tag, "_res24"}, res24, 0);
        check({tag, "_rv24"}, rv24, 0);
        check({tag, "_ovf24"}, ovf24, 0);
        check({tag, "_busy24"}, busy24, 0);
        check({tag, "_res17"}, res17, 0);
        check({tag, "_rv17"}, rv17, 0);
        check({tag, "_busy17"}, busy17, 0);
    endtask

    // Scoreboard: pop and compare on every result handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && rv24 && rready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got %h with no pending operation", res24);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_res24", res24, e.r24);
                check("sb_ovf24", ovf24, e.o24);
                check("sb_rv17", rv17, 1);
                check("sb_res17", res17, e.r17);
                check("sb_ovf17", ovf17, e.o17);
            end
        end
    end

    // Run one operation from the table; hold > 0 keeps Result_Ready low that many DONE cycles.
    task automatic run_op(input int idx, input int hold);
        vec_t v;
        int   cyc;
        int   gsum;
        v      = vecs[idx];
        gsum   = 0;
        rready = (hold == 0);
        start  = 1'b1;
        length = v.len;
        sb.push_back({v.r24, v.o24, v.r17, v.o17});
        @(posedge clk); #1;
        start  = 1'b0;
        length = 4'($urandom);
        cyc    = 1;
        check("start_ovf24_clear", ovf24, 0);
        check("start_ovf17_clear", ovf17, 0);
        check("start_res24_clear", res24, 0);
        check("start_enable", en24, v.len != 0);
        check("start_busy", busy24, 1);
        for (int i = 0; i < int'(v.len); i++) begin
            for (int g = 0; g < int'(v.gap[i]); g++) begin
                pvalid  = 1'b0;
                product = 16'($urandom);
                check("gap_rv", rv24, 0);
                @(posedge clk); #1;
                cyc++;
                gsum++;
            end
            pvalid  = 1'b1;
            product = v.prod[i];
            check("accum_rv", rv24, 0);
            check("accum_pready", pready24, 1);
            check("accum_enable17", en17, 1);
            @(posedge clk); #1;
            cyc++;
        end
        pvalid  = 1'b0;
        product = 16'($urandom);
        check("latency", cyc, v.len + gsum + 1);
        check("done_rv24", rv24, 1);
        check("done_rv17", rv17, 1);
        check("done_pready", pready24, 0);
        check("done_enable", en24, 0);
        check("done_busy", busy24, 1);
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                start = (h == 2);
                @(posedge clk); #1;
                check("hold_rv", rv24, 1);
                check("hold_res24", res24, v.r24);
                check("hold_ovf17", ovf17, v.o17);
            end
            // Start alongside the handshake must also be ignored.
            start  = 1'b1;
            rready = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check("after_rv", rv24, 0);
        check("after_busy", busy24, 0);
        check("after_enable", en24, 0);
        check("idle_res24_kept", res24, v.r24);
        check("idle_ovf24_kept", ovf24, v.o24);
        check("idle_res17_kept", res17, v.r17);
        check("idle_ovf17_kept", ovf17, v.o17);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 7; k++) vecs[k] = '0;
        // Back-to-back small products.
        vecs[0].len = 4'd3;
        vecs[0].prod[0] = 16'h0010; vecs[0].prod[1] = 16'h0020; vecs[0].prod[2] = 16'h0030;
        vecs[0].r24 = 24'h000060;   vecs[0].r17 = 17'h00060;
        // Overflows only the 17-bit accumulator.
        vecs[1].len = 4'd3;
        for (int i = 0; i < 3; i++) vecs[1].prod[i] = 16'hFE01;
        vecs[1].r24 = 24'h02FA03;   vecs[1].r17 = 17'h0FA03; vecs[1].o17 = 1'b1;
        // Valid pattern 1,0,0,1,0,1,1.
        vecs[2].len = 4'd4;
        for (int i = 0; i < 4; i++) vecs[2].prod[i] = 16'(i + 1);
        vecs[2].gap[1] = 2'd2;      vecs[2].gap[2] = 2'd1;
        vecs[2].r24 = 24'h00000A;   vecs[2].r17 = 17'h0000A;
        // Zero-length operation.
        vecs[3].len = 4'd0;
        // Maximum length with full-scale products.
        vecs[4].len = 4'd15;
        for (int i = 0; i < 15; i++) vecs[4].prod[i] = 16'hFFFF;
        vecs[4].r24 = 24'h0EFFF1;   vecs[4].r17 = 17'h0FFF1; vecs[4].o17 = 1'b1;
        // Sum lands exactly on bit 16 without overflowing either width.
        vecs[5].len = 4'd2;
        vecs[5].prod[0] = 16'hFFFF; vecs[5].prod[1] = 16'h0001;
        vecs[5].r24 = 24'h010000;   vecs[5].r17 = 17'h10000;
        // Single term after a reset abort.
        vecs[6].len = 4'd1;
        vecs[6].prod[0] = 16'h0005;
        vecs[6].r24 = 24'h000005;   vecs[6].r17 = 17'h00005;

        rst_n = 1'b0; start = 1'b0; length = '0; product = '0; pvalid = 1'b0; rready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(0, 0);
        run_op(1, 0);
        run_op(2, 0);
        run_op(3, 0);
        run_op(4, 5);
        run_op(5, 0);

        // Abort a five-term operation after two accepted terms.
        rready = 1'b1;
        start  = 1'b1;
        length = 4'd5;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pvalid  = 1'b1;
            product = 16'h0100;
            @(posedge clk); #1;
        end
        check("pre_abort_res24", res24, 24'h000200);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        pvalid = 1'b0;
        check_all_zero("abort");
        @(posedge clk); #1;
        check("abort_stays_idle", busy24, 0);

        run_op(6, 0);

        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
